// File: rtl/actel_c2_cfg_loader.sv
// actel_c2_cfg_loader
//  Serial configuration writer for a bank of Actel C2 mux logic cells. A framed 1-bit
//  stream (header, NUM_CELLS*8 data bits, one even-parity bit, all MSB-first) is taken
//  over a valid/ready handshake into a shadow register. The shadow is copied to cfg_word
//  in a single edge only once the parity bit checks out. A failed or aborted frame
//  therefore never disturbs the committed configuration.
//  Per-cell word = {d00,d01,d10,d11,a1,b1,a0,b0}; bit 7 = d00.
//
// Ports
//  clk        rising-edge clock
//  rst_n      asynchronous active-low reset
//  start      begin frame reception (only honoured in idle, done or error)
//  ser_valid  ser_data valid
//  ser_data   serial bit
//  ser_ready  loader can accept a bit (header, data and parity phases)
//  cfg_word   committed config; cell i at [8*i+7:8*i]
//  busy       frame in progress
//  done       1-cycle pulse: frame committed
//  err        held high after a header or parity error until the next start
module actel_c2_cfg_loader #(
  parameter int unsigned NUM_CELLS = 4,
  parameter logic [7:0]  HDR       = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   ser_valid,
  input  logic                   ser_data,
  output logic                   ser_ready,
  output logic [NUM_CELLS*8-1:0] cfg_word,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned NBITS = NUM_CELLS * 8;
  // NBITS is at least 8, so this also covers the 8-bit header count.
  localparam int unsigned CW    = $clog2(NBITS);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StPar,
    StDone,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       hdr_q, hdr_d;
  logic             par_q, par_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [NBITS-1:0] cfg_q, cfg_d;

  logic             xfer;
  logic [7:0]       hdr_next;
  logic [CW-1:0]    bit_idx;

  assign xfer     = ser_valid && ser_ready;
  assign hdr_next = {hdr_q[6:0], ser_data};
  // Data arrives cell 0 first and MSB-first within a cell: data bit k lands at cell k/8,
  // bit 7-(k%8), i.e. the running count with its low three bits inverted.
  assign bit_idx  = cnt_q ^ CW'(7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hdr_q    <= '0;
      par_q    <= 1'b0;
      shadow_q <= '0;
      cfg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      par_q    <= par_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    par_d     = par_q;
    shadow_d  = shadow_q;
    cfg_d     = cfg_q;
    ser_ready = 1'b0;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHdr;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end

      StHdr: begin
        ser_ready = 1'b1;
        if (xfer) begin
          hdr_d = hdr_next;
          if (cnt_q == CW'(7)) begin
            cnt_d   = '0;
            state_d = (hdr_next == HDR) ? StData : StErr;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      StData: begin
        ser_ready = 1'b1;
        if (xfer) begin
          shadow_d[bit_idx] = ser_data;
          par_d             = par_q ^ ser_data;
          if (cnt_q == CW'(NBITS - 1)) begin
            cnt_d   = '0;
            state_d = StPar;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      StPar: begin
        ser_ready = 1'b1;
        if (xfer) begin
          if ((par_q ^ ser_data) == 1'b0) begin
            cfg_d   = shadow_q;
            state_d = StDone;
          end else begin
            state_d = StErr;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign cfg_word = cfg_q;
  assign busy     = ser_ready;
  assign done     = (state_q == StDone);
  assign err      = (state_q == StErr);

endmodule

// File: tb/tb_actel_c2_cfg_loader.sv
// Bench for actel_c2_cfg_loader with NUM_CELLS=2. Each frame's expected outcome (commit or
// error, plus the cfg_word that must be visible then) is queued when the frame is issued;
// a monitor pops one entry per done pulse or rising err and compares.
module tb_actel_c2_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ser_valid;
  logic        ser_data;
  logic        ser_ready;
  logic [15:0] cfg_word;
  logic        busy;
  logic        done;
  logic        err;

  actel_c2_cfg_loader #(
    .NUM_CELLS(2),
    .HDR      (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ser_valid(ser_valid),
    .ser_data (ser_data),
    .ser_ready(ser_ready),
    .cfg_word (cfg_word),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] cfg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_cnt = 0;
  bit   err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [15:0] cfg);
    exp_t e;
    e.is_err = is_err;
    e.cfg    = cfg;
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per commit or error event.
  always @(negedge clk) begin
    if (rst_n && (done || (err && !err_prev))) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, done, err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind_err", {31'd0, err}, {31'd0, e.is_err});
        check("event_kind_done", {31'd0, done}, {31'd0, !e.is_err});
        check("event_cfg_word", {16'd0, cfg_word}, {16'd0, e.cfg});
      end
    end
    if (ser_ready) rdy_cnt++;
    err_prev = err;
  end

  function automatic logic calc_par(input logic [15:0] d);
    return ^d;
  endfunction

  // Leaves the bench at a negedge with the loader in the header phase.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // data holds cell 0 in [7:0]; that byte goes out first, MSB-first.
  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] data, input logic par,
                            input int pct, input bit mid_start, input int nbits,
                            output bit done_seen);
    logic [24:0] fr;
    fr = {hdr, data[7:0], data[15:8], par};
    done_seen = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      int tries;
      bit sent;
      tries = 0;
      sent  = 1'b0;
      while (!sent) begin
        ser_data  = fr[24-i];
        ser_valid = (pct >= 100) || (int'($urandom_range(99)) < pct);
        if (mid_start) start = ($urandom_range(7) == 0);
        sent = ser_valid && ser_ready;
        @(negedge clk);
        tries++;
        if (!sent && tries > 200) begin
          checks++;
          errors++;
          $display("FAIL handshake_timeout actual=bit%0d_not_taken required=taken", i);
          ser_valid = 1'b0;
          start     = 1'b0;
          return;
        end
      end
    end
    done_seen = done;
    ser_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    bit ds;
    rst_n     = 1'b0;
    start     = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;

    // 1: reset values, then an asynchronous reset in the middle of a cycle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ser_ready", {31'd0, ser_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_cfg_word", {16'd0, cfg_word}, 32'h0);
    rst_n = 1'b1;
    do_start();
    send_frame(8'hA5, 16'hF03C, 1'b0, 100, 1'b0, 10, ds);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_ser_ready", {31'd0, ser_ready}, 32'd0);
    check("async_reset_cfg_word", {16'd0, cfg_word}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: good frame, valid held high
    rdy_cnt = 0;
    push_exp(1'b0, 16'hF03C);
    do_start();
    send_frame(8'hA5, 16'hF03C, calc_par(16'hF03C), 100, 1'b0, 25, ds);
    check("good_done_latency", {31'd0, ds}, 32'd1);
    check("good_ready_cycles", rdy_cnt, 32'd25);
    check("good_cfg_word", {16'd0, cfg_word}, 32'hF03C);
    check("good_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    // 3: bad header, then a good frame
    push_exp(1'b1, 16'hF03C);
    do_start();
    send_frame(8'hA4, 16'h0000, 1'b0, 100, 1'b0, 8, ds);
    check("badhdr_err", {31'd0, err}, 32'd1);
    check("badhdr_ser_ready", {31'd0, ser_ready}, 32'd0);
    check("badhdr_cfg_word", {16'd0, cfg_word}, 32'hF03C);
    push_exp(1'b0, 16'h8155);
    do_start();
    check("start_clears_err", {31'd0, err}, 32'd0);
    send_frame(8'hA5, 16'h8155, calc_par(16'h8155), 100, 1'b0, 25, ds);
    check("frame2_done", {31'd0, ds}, 32'd1);
    check("frame2_cfg_word", {16'd0, cfg_word}, 32'h8155);

    // 4: parity error (ones over data = 5, parity 0 sent)
    repeat (2) @(negedge clk);
    push_exp(1'b1, 16'h8155);
    do_start();
    send_frame(8'hA5, 16'h3412, 1'b0, 100, 1'b0, 25, ds);
    check("parerr_no_done", {31'd0, ds}, 32'd0);
    check("parerr_err", {31'd0, err}, 32'd1);
    check("parerr_cfg_word", {16'd0, cfg_word}, 32'h8155);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);

    // 5: sparse valid plus stray start pulses mid-frame
    push_exp(1'b0, 16'hF03C);
    do_start();
    check("start_clears_err2", {31'd0, err}, 32'd0);
    send_frame(8'hA5, 16'hF03C, calc_par(16'hF03C), 30, 1'b1, 25, ds);
    check("gaps_done", {31'd0, ds}, 32'd1);
    check("gaps_cfg_word", {16'd0, cfg_word}, 32'hF03C);

    // 6: reset after 5 data bits, then a good frame
    repeat (2) @(negedge clk);
    do_start();
    send_frame(8'hA5, 16'h8155, 1'b0, 100, 1'b0, 13, ds);
    #2 rst_n = 1'b0;
    #1;
    check("middata_reset_cfg_word", {16'd0, cfg_word}, 32'h0);
    check("middata_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, 16'h8155);
    do_start();
    send_frame(8'hA5, 16'h8155, calc_par(16'h8155), 100, 1'b0, 25, ds);
    check("after_reset_done", {31'd0, ds}, 32'd1);
    check("after_reset_cfg_word", {16'd0, cfg_word}, 32'h8155);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
